// File: rtl/cpu_core.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------------------
// cpu_core - two-stage RV32I core with internal IMEM/DMEM; CPU_CSR_EN adds tohost. Rev 1.0
// -----------------------------------------------------------------------------------------

module cpu_regfile (
   input  logic        clk,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr_a,
   input  logic [4:0]  raddr_b,
   output logic [31:0] rdata_a,
   output logic [31:0] rdata_b
);
   logic [31:0] mem [0:31];

   always_ff @(posedge clk) begin
      if (we && (waddr != 5'd0)) mem[waddr] <= wdata;
   end

   assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : mem[raddr_a];
   assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : mem[raddr_b];
endmodule

module cpu_imem (
   input  logic        clk,
   input  logic        we,
   input  logic [13:0] waddr,
   input  logic [31:0] wdata,
   input  logic [13:0] raddr,
   output logic [31:0] rdata
);
   logic [31:0] mem [0:16383];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

module cpu_dmem (
   input  logic        clk,
   input  logic        we,
   input  logic [3:0]  be,
   input  logic [13:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata
);
   logic [31:0] mem [0:16383];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem[addr];
endmodule

module cpu_core #(
   parameter logic [31:0] CPU_CLOCK_FREQ = 32'd50_000_000,
   parameter logic [31:0] RESET_PC       = 32'h1000_0000
) (
   input  logic clk,
   input  logic rst,
   input  logic bp_enable,
   input  logic serial_in,
   output logic serial_out
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   logic [31:0] pc, x_pc, instr;
   logic        x_valid;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_val, rs2_val, alu_b, alu_out;
   logic [4:0]  shamt;
   logic        br_taken, redirect;
   logic [31:0] target;
   logic [31:0] mem_addr, dmem_rdata, load_word, load_data, store_data;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic        mapped, load_ok, store_we;
   logic [3:0]  store_be;
   logic        rd_we;
   logic [31:0] rd_data;
   logic        csr_sel;
   logic [31:0] csr_rdata;
   logic        unused_ok;

   assign serial_out = 1'b1;
   assign unused_ok  = &{1'b0, bp_enable, serial_in, CPU_CLOCK_FREQ, mem_addr[27:16]};

   cpu_imem imem (
      .clk(clk), .we(1'b0), .waddr(14'd0), .wdata(32'd0),
      .raddr(pc[15:2]), .rdata(instr)
   );

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u  = {instr[31:12], 12'd0};
   assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   cpu_regfile rf (
      .clk(clk), .we(x_valid && rd_we), .waddr(instr[11:7]), .wdata(rd_data),
      .raddr_a(instr[19:15]), .raddr_b(instr[24:20]),
      .rdata_a(rs1_val), .rdata_b(rs2_val)
   );

   assign alu_b = (opcode == OP_REG) ? rs2_val : imm_i;
   assign shamt = alu_b[4:0];

   always_comb begin
      alu_out = 32'd0;
      case (funct3)
         3'b000: alu_out = (opcode == OP_REG && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
         3'b001: alu_out = rs1_val << shamt;
         3'b010: alu_out = {31'd0, $signed(rs1_val) < $signed(alu_b)};
         3'b011: alu_out = {31'd0, rs1_val < alu_b};
         3'b100: alu_out = rs1_val ^ alu_b;
         3'b101: begin
            if (instr[30]) alu_out = $signed(rs1_val) >>> shamt;
            else           alu_out = rs1_val >> shamt;
         end
         3'b110: alu_out = rs1_val | alu_b;
         default: alu_out = rs1_val & alu_b;
      endcase
   end

   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         3'b000: br_taken = (rs1_val == rs2_val);
         3'b001: br_taken = (rs1_val != rs2_val);
         3'b100: br_taken = ($signed(rs1_val) <  $signed(rs2_val));
         3'b101: br_taken = ($signed(rs1_val) >= $signed(rs2_val));
         3'b110: br_taken = (rs1_val <  rs2_val);
         3'b111: br_taken = (rs1_val >= rs2_val);
         default: br_taken = 1'b0;
      endcase
   end

   // Any redirect squashes the instruction fetched in the same cycle.
   always_comb begin
      redirect = 1'b0;
      target   = x_pc + imm_b;
      if (x_valid) begin
         case (opcode)
            OP_JAL: begin
               redirect = 1'b1;
               target   = x_pc + imm_j;
            end
            OP_JALR: begin
               redirect = 1'b1;
               target   = (rs1_val + imm_i) & ~32'd1;
            end
            OP_BRANCH: redirect = br_taken;
            default:   redirect = 1'b0;
         endcase
      end
   end

   assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
   assign mapped   = (mem_addr[31:28] == 4'h1);
   assign store_we = x_valid && (opcode == OP_STORE) && mapped;

   cpu_dmem dmem (
      .clk(clk), .we(store_we), .be(store_be), .addr(mem_addr[15:2]),
      .wdata(store_data), .rdata(dmem_rdata)
   );

   always_comb begin
      load_word = mapped ? dmem_rdata : 32'd0;
      load_byte = load_word[{mem_addr[1:0], 3'b000} +: 8];
      load_half = mem_addr[1] ? load_word[31:16] : load_word[15:0];
      load_ok   = 1'b1;
      load_data = 32'd0;
      case (funct3)
         3'b000: load_data = {{24{load_byte[7]}}, load_byte};
         3'b001: load_data = {{16{load_half[15]}}, load_half};
         3'b010: load_data = load_word;
         3'b100: load_data = {24'd0, load_byte};
         3'b101: load_data = {16'd0, load_half};
         default: load_ok = 1'b0;
      endcase
   end

   always_comb begin
      store_be   = 4'b0000;
      store_data = rs2_val;
      case (funct3)
         3'b000: begin
            store_be   = 4'b0001 << mem_addr[1:0];
            store_data = {4{rs2_val[7:0]}};
         end
         3'b001: begin
            store_be   = mem_addr[1] ? 4'b1100 : 4'b0011;
            store_data = {2{rs2_val[15:0]}};
         end
         3'b010: store_be = 4'b1111;
         default: store_be = 4'b0000;
      endcase
   end

`ifdef CPU_CSR_EN
   localparam logic [6:0]  OP_SYSTEM   = 7'b1110011;
   localparam logic [11:0] CSR_TOHOST  = 12'h51E;
   logic [31:0] tohost;
   logic        csr_hit;

   // Only CSRRW (001) and CSRRWI (101) are decoded; other SYSTEM ops stay NOPs.
   assign csr_sel   = (opcode == OP_SYSTEM) && (funct3[1:0] == 2'b01);
   assign csr_hit   = (instr[31:20] == CSR_TOHOST);
   assign csr_rdata = csr_hit ? tohost : 32'd0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tohost <= 32'd0;
      end else if (x_valid && csr_sel && csr_hit) begin
         tohost <= funct3[2] ? {27'd0, instr[19:15]} : rs1_val;
      end
   end
`else
   assign csr_sel   = 1'b0;
   assign csr_rdata = 32'd0;
`endif

   always_comb begin
      rd_we   = 1'b0;
      rd_data = 32'd0;
      case (opcode)
         OP_LUI:   begin rd_we = 1'b1; rd_data = imm_u;        end
         OP_AUIPC: begin rd_we = 1'b1; rd_data = x_pc + imm_u; end
         OP_JAL,
         OP_JALR:  begin rd_we = 1'b1; rd_data = x_pc + 32'd4; end
         OP_LOAD:  begin rd_we = load_ok; rd_data = load_data; end
         OP_IMM,
         OP_REG:   begin rd_we = 1'b1; rd_data = alu_out;      end
         default: begin
            if (csr_sel) begin
               rd_we   = 1'b1;
               rd_data = csr_rdata;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc      <= RESET_PC;
         x_pc    <= RESET_PC;
         x_valid <= 1'b0;
      end else begin
         x_pc    <= pc;
         x_valid <= !redirect;
         pc      <= redirect ? target : pc + 32'd4;
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_cpu_core.sv
`timescale 1ns/1ps
`default_nettype none
// tb_cpu_core: directed RV32I programs checked against an instruction-level reference model.

module tb_cpu_core;
   localparam logic [31:0] RST_PC = 32'h1000_0000;
   localparam logic [31:0] HALT   = 32'h0000_006F;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic bp_enable = 1'b0;
   logic serial_in = 1'b1;
   logic serial_out;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] prog [0:63];
   int          plen;
   logic [31:0] m_rf [0:31];
   logic [31:0] m_dm [int];

   cpu_core #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .bp_enable(bp_enable),
      .serial_in(serial_in), .serial_out(serial_out)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      n_cmp++;
      if (serial_out !== 1'b1) begin
         n_bad++;
         $display("FAIL serial_out at %0t: got %b, want 1", $time, serial_out);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // ---------------- instruction encoders ----------------
   function automatic logic [31:0] e_i(int imm, int rs1, int f3, int rd, int op);
      logic [31:0] t;
      t = imm;
      return {t[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
   endfunction
   function automatic logic [31:0] e_r(int f7, int f3, int rd, int rs1, int rs2);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
   endfunction
   function automatic logic [31:0] e_s(int f3, int rs2, int rs1, int imm);
      logic [31:0] t;
      t = imm;
      return {t[11:5], 5'(rs2), 5'(rs1), 3'(f3), t[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] e_b(int f3, int rs1, int rs2, int off);
      logic [31:0] t;
      t = off;
      return {t[12], t[10:5], 5'(rs2), 5'(rs1), 3'(f3), t[4:1], t[11], 7'h63};
   endfunction
   function automatic logic [31:0] e_u(int op, int rd, int imm20);
      logic [31:0] t;
      t = imm20;
      return {t[19:0], 5'(rd), 7'(op)};
   endfunction
   function automatic logic [31:0] e_j(int rd, int off);
      logic [31:0] t;
      t = off;
      return {t[20], t[10:1], t[11], t[19:12], 5'(rd), 7'h6F};
   endfunction
   function automatic logic [31:0] addi(int rd, int rs1, int imm);
      return e_i(imm, rs1, 0, rd, 'h13);
   endfunction

   task automatic put(input logic [31:0] w);
      prog[plen] = w;
      plen++;
   endtask

   task automatic build(input int p);
      for (int i = 0; i < 64; i++) prog[i] = 32'd0;
      plen = 0;
      case (p)
         0: begin
            put(addi(1, 0, 100)); put(addi(2, 0, 200)); put(e_r(0, 0, 1, 1, 2));
            put(addi(20, 0, 1));  put(HALT);
         end
         1: begin
            put(addi(2, 0, 100)); put(addi(3, 0, 100)); put(e_b(0, 2, 3, 8));
            put(addi(1, 0, 700)); put(addi(1, 0, 500)); put(addi(20, 0, 2)); put(HALT);
         end
         2: begin
            put(e_u('h37, 10, 'h10004)); put(e_u('h37, 11, 'hDEADC)); put(addi(11, 11, -273));
            put(e_s(2, 11, 10, 0));      put(e_i(0, 10, 2, 1, 3));    put(e_i(0, 10, 0, 2, 3));
            put(e_i(2, 10, 5, 3, 3));    put(addi(12, 0, 'h12));      put(e_s(0, 12, 10, 1));
            put(e_i(0, 10, 2, 4, 3));    put(e_i(1, 10, 2, 15, 3));   put(e_i(2, 10, 1, 6, 3));
            put(e_i(3, 10, 4, 7, 3));    put(e_u('h37, 13, 'h20000)); put(e_s(2, 11, 13, 0));
            put(e_i(0, 13, 2, 8, 3));    put(e_u('h37, 14, 'h10000)); put(e_i(0, 14, 2, 9, 3));
            put(e_s(1, 12, 10, 6));      put(addi(20, 0, 3));         put(HALT);
         end
         3: begin
            put(addi(1, 0, 1)); put(addi(2, 0, 2)); put(addi(3, 0, 3)); put(addi(0, 0, 5));
            put(e_j(5, 16));    put(addi(6, 0, 66)); put(addi(20, 0, 4)); put(HALT);
            put(addi(7, 0, 77)); put(e_i(1, 5, 0, 8, 'h67));
         end
         default: begin
            put(addi(1, 0, -16));        put(addi(2, 0, 3));          put(e_r(32, 5, 3, 1, 2));
            put(e_r(0, 5, 4, 1, 2));     put(e_r(0, 1, 5, 1, 2));     put(e_r(32, 0, 6, 2, 1));
            put(e_r(0, 2, 7, 1, 2));     put(e_r(0, 3, 8, 1, 2));     put(e_i(255, 1, 4, 9, 'h13));
            put(e_i('h402, 1, 5, 10, 'h13)); put(e_i(127, 1, 7, 11, 'h13)); put(e_u('h17, 12, 1));
            put(e_b(4, 1, 2, 8));        put(addi(13, 0, 99));        put(e_b(7, 1, 2, 8));
            put(addi(14, 0, 98));        put(e_b(1, 2, 2, 8));        put(e_r(0, 6, 15, 1, 2));
            put(e_i(-1, 2, 3, 16, 'h13)); put(e_i(31, 2, 1, 17, 'h13)); put(e_r(0, 0, 18, 17, 17));
            put(addi(20, 0, 5));         put(HALT);
         end
      endcase
   endtask

   // ---------------- reference model: one instruction per step ----------------
   function automatic logic [31:0] dm_word(input logic [13:0] i);
      return m_dm.exists(int'(i)) ? m_dm[int'(i)] : 32'd0;
   endfunction

   task automatic model_run(output int mark_edge);
      logic [31:0] pc, ins, a, b, ii, si, bi, ui, ji, y, addr, w, res, nxt;
      logic [4:0]  rd, sh;
      logic [2:0]  f3;
      logic [6:0]  op;
      bit          wr, jump, take;
      int          bubbles, idx, lane;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_dm.delete();
      pc = RST_PC; bubbles = 0; mark_edge = -1;
      for (int n = 0; n < 200; n++) begin
         idx = int'((pc - RST_PC) >> 2);
         ins = (idx >= 0 && idx < 64) ? prog[idx] : 32'd0;
         if (ins == HALT) break;
         op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12];
         a  = m_rf[ins[19:15]]; b = m_rf[ins[24:20]];
         ii = {{20{ins[31]}}, ins[31:20]};
         si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         bi = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         ui = {ins[31:12], 12'd0};
         ji = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         wr = 0; jump = 0; res = 0; nxt = pc + 4;
         case (op)
            7'h37: begin wr = 1; res = ui; end
            7'h17: begin wr = 1; res = pc + ui; end
            7'h6F: begin wr = 1; res = pc + 4; nxt = pc + ji; jump = 1; end
            7'h67: begin wr = 1; res = pc + 4; nxt = (a + ii) & 32'hFFFF_FFFE; jump = 1; end
            7'h63: begin
               case (f3)
                  0: take = (a == b);
                  1: take = (a != b);
                  4: take = ($signed(a) < $signed(b));
                  5: take = ($signed(a) >= $signed(b));
                  6: take = (a < b);
                  7: take = (a >= b);
                  default: take = 0;
               endcase
               if (take) begin nxt = pc + bi; jump = 1; end
            end
            7'h03: begin
               addr = a + ii;
               w    = (addr[31:28] == 4'h1) ? dm_word(addr[15:2]) : 32'd0;
               lane = int'(addr[1:0]);
               wr   = 1;
               case (f3)
                  0: begin res = (w >> (8 * lane)) & 32'hFF; if (res[7]) res = res | 32'hFFFF_FF00; end
                  1: begin res = addr[1] ? (w >> 16) : (w & 32'hFFFF); if (res[15]) res = res | 32'hFFFF_0000; end
                  2: res = w;
                  4: res = (w >> (8 * lane)) & 32'hFF;
                  5: res = addr[1] ? (w >> 16) : (w & 32'hFFFF);
                  default: wr = 0;
               endcase
            end
            7'h23: begin
               addr = a + si;
               lane = int'(addr[1:0]);
               if (addr[31:28] == 4'h1) begin
                  w = dm_word(addr[15:2]);
                  case (f3)
                     0: w[8*lane +: 8] = b[7:0];
                     1: if (addr[1]) w[31:16] = b[15:0]; else w[15:0] = b[15:0];
                     2: w = b;
                     default: ;
                  endcase
                  m_dm[int'(addr[15:2])] = w;
               end
            end
            7'h13, 7'h33: begin
               wr = 1;
               y  = (op == 7'h33) ? b : ii;
               sh = y[4:0];
               case (f3)
                  0: if (op == 7'h33 && ins[30]) res = a - y; else res = a + y;
                  1: res = a << sh;
                  2: res = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
                  3: res = (a < y) ? 32'd1 : 32'd0;
                  4: res = a ^ y;
                  5: if (ins[30]) res = $signed(a) >>> sh; else res = a >> sh;
                  6: res = a | y;
                  default: res = a & y;
               endcase
            end
            default: ;
         endcase
         if (wr && rd != 0) m_rf[rd] = res;
         if (wr && rd == 20) mark_edge = 2 + n + bubbles;
         if (jump) bubbles++;
         pc = nxt;
      end
   endtask

   // ---------------- run one program against the model ----------------
   task automatic run_prog(input int p, input int marker, input bit mid_reset, output int edges);
      int  exp_edge;
      bit  hit;
      rst = 1'b0;
      build(p);
      for (int i = 0; i < 64; i++)    dut.imem.mem[i] = prog[i];
      for (int i = 0; i < 32; i++)    dut.rf.mem[i]   = 32'd0;
      for (int i = 0; i < 16384; i++) dut.dmem.mem[i] = 32'd0;
      model_run(exp_edge);
      @(negedge clk); @(negedge clk);
      check($sformatf("p%0d_reset_pc", p), dut.pc, RST_PC);
      rst = 1'b1;
      if (mid_reset) begin
         repeat (4) @(negedge clk);
         rst = 1'b0;
         repeat (3) @(negedge clk);
         check("midreset_pc", dut.pc, RST_PC);
         check("midreset_serial_out", {31'd0, serial_out}, 32'd1);
         rst = 1'b1;
      end
      edges = 0; hit = 0;
      while (!hit && edges < 90) begin
         @(posedge clk);
         edges++;
         #1;
         if (dut.rf.mem[20] == 32'(marker)) hit = 1;
      end
      check($sformatf("p%0d_done", p), {31'd0, hit}, 32'd1);
      check($sformatf("p%0d_cycles", p), 32'(edges), 32'(exp_edge));
      repeat (3) @(negedge clk);
      for (int i = 0; i < 32; i++) check($sformatf("p%0d_rf_x%0d", p, i), dut.rf.mem[i], m_rf[i]);
      check($sformatf("p%0d_dm0", p),    dut.dmem.mem[0],       dm_word(14'd0));
      check($sformatf("p%0d_dm1000", p), dut.dmem.mem[14'h1000], dm_word(14'h1000));
      check($sformatf("p%0d_dm1001", p), dut.dmem.mem[14'h1001], dm_word(14'h1001));
   endtask

   initial begin
      int e;
      run_prog(0, 1, 0, e);
      check("add_x1", dut.rf.mem[1], 32'd300);
      check("add_edge", 32'(e), 32'd5);

      bp_enable = 1'b1;
      run_prog(1, 2, 0, e);
      check("beq_x1", dut.rf.mem[1], 32'd500);
      check("beq_x2", dut.rf.mem[2], 32'd100);
      check("beq_edge", 32'(e), 32'd7);

      bp_enable = 1'b0;
      run_prog(2, 3, 0, e);
      check("ls_lw",      dut.rf.mem[1],  32'hDEAD_BEEF);
      check("ls_lb",      dut.rf.mem[2],  32'hFFFF_FFEF);
      check("ls_lhu",     dut.rf.mem[3],  32'h0000_DEAD);
      check("ls_sb_lw",   dut.rf.mem[4],  32'hDEAD_12EF);
      check("ls_lh",      dut.rf.mem[6],  32'hFFFF_DEAD);
      check("ls_lbu",     dut.rf.mem[7],  32'h0000_00DE);
      check("ls_unmapped", dut.rf.mem[8], 32'd0);
      check("ls_dropped", dut.rf.mem[9],  32'd0);
      check("ls_misalign", dut.rf.mem[15], 32'hDEAD_12EF);
      check("ls_sh_word", dut.dmem.mem[14'h1001], 32'h0012_0000);

      run_prog(3, 4, 0, e);
      check("jmp_x5", dut.rf.mem[5], 32'h1000_0014);
      check("jmp_x0", dut.rf.mem[0], 32'd0);
      check("jmp_x8", dut.rf.mem[8], 32'h1000_0028);
      check("jmp_x7", dut.rf.mem[7], 32'd77);
      check("jmp_x6", dut.rf.mem[6], 32'd66);
      check("jmp_edge", 32'(e), 32'd12);

      run_prog(4, 5, 0, e);
      check("alu_sra",  dut.rf.mem[3],  32'hFFFF_FFFE);
      check("alu_srl",  dut.rf.mem[4],  32'h1FFF_FFFE);
      check("alu_sub",  dut.rf.mem[6],  32'd19);
      check("alu_srai", dut.rf.mem[10], 32'hFFFF_FFFC);
      check("alu_skip1", dut.rf.mem[13], 32'd0);
      check("alu_skip2", dut.rf.mem[14], 32'd0);
      check("alu_slli", dut.rf.mem[17], 32'h8000_0000);
      check("alu_wrap", dut.rf.mem[18], 32'd0);

      run_prog(2, 3, 1, e);
      check("rerun_x4", dut.rf.mem[4], 32'hDEAD_12EF);
      check("rerun_x3", dut.rf.mem[3], 32'h0000_DEAD);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

`default_nettype wire
